// File: rtl/cq_offset_rr_mgt.sv
// Round-robin CQ producer-offset allocator with per-CQ owner bit and a host clear port.
// Optional CQ_OFFSET_STAT_EN adds ov_stat: grant counter r at [r*32+:32], wrap counter in the top 32 bits.
module cq_offset_rr_mgt #(
  parameter int NUM_REQ  = 3,
  parameter int CQ_NUM   = 16384,
  parameter int CQ_IDX_W = 14,
  parameter int OFFSET_W = 24,
  parameter int CQE_LEN  = 32,
  parameter int LOG_SZ_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ*CQ_IDX_W-1:0]  iv_req_cq_index,
  input  logic [NUM_REQ*LOG_SZ_W-1:0]  iv_req_cq_log_size,
  output logic [NUM_REQ-1:0]           o_resp_valid,
  output logic [NUM_REQ*OFFSET_W-1:0]  ov_resp_cq_offset,
  output logic [NUM_REQ-1:0]           ov_resp_owner,
  input  logic                         i_clr_valid,
  input  logic [CQ_IDX_W-1:0]          iv_clr_cq_index,
  output logic                         o_clr_ready,
  output logic                         o_init_finish
`ifdef CQ_OFFSET_STAT_EN
  ,
  output logic [NUM_REQ*32+31:0]       ov_stat
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ENT_W = OFFSET_W + 1;
  localparam int LEN_W = OFFSET_W + 1;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [LEN_W-1:0] ring_len(input logic [LOG_SZ_W-1:0] lsz);
    return LEN_W'(CQE_LEN) << lsz;
  endfunction

  state_t                state_q, state_d;
  logic [CQ_IDX_W-1:0]   cnt_q, cnt_d;
  logic                  init_fin_q, init_fin_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  logic                  run, clr_acc, gnt_any;
  logic [NUM_REQ-1:0]    gnt;
  logic [PTR_W-1:0]      gnt_id;
  logic [CQ_IDX_W-1:0]   rd_addr;
  logic [LOG_SZ_W-1:0]   acc_lsz;

  logic [ENT_W-1:0]      mem_q [CQ_NUM];
  logic [ENT_W-1:0]      rdata_p1_q;
  logic                  vld_p1_q, clr_p1_q;
  logic [PTR_W-1:0]      id_p1_q;
  logic [CQ_IDX_W-1:0]   idx_p1_q;
  logic [LOG_SZ_W-1:0]   lsz_p1_q;

  logic                  we;
  logic [CQ_IDX_W-1:0]   wr_addr;
  logic [ENT_W-1:0]      wr_data;
  logic                  wr_vld_p2_q;
  logic [CQ_IDX_W-1:0]   wr_idx_p2_q;
  logic [ENT_W-1:0]      wr_data_p2_q;

  logic [ENT_W-1:0]      cur_p1, upd_p1;
  logic [LEN_W-1:0]      len_p1, nxt_p1;
  logic                  wrap_p1;

  logic [NUM_REQ-1:0]          resp_vld_q, resp_vld_d;
  logic [NUM_REQ*OFFSET_W-1:0] resp_off_q, resp_off_d;
  logic [NUM_REQ-1:0]          resp_own_q, resp_own_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    init_fin_d = init_fin_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CQ_IDX_W'(CQ_NUM - 1)) begin
        state_d    = ST_RUN;
        cnt_d      = '0;
        init_fin_d = 1'b1;
      end
    end
  end

  // Stage 0: arbitration (clear wins outright, then rotating first-valid search)
  always_comb begin
    int sel;
    sel     = 0;
    run     = (state_q == ST_RUN);
    clr_acc = run & i_clr_valid;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    if (run && !i_clr_valid) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sel = (int'(ptr_q) + k) % NUM_REQ;
        if (!gnt_any && i_req_valid[sel]) begin
          gnt_any     = 1'b1;
          gnt[sel]    = 1'b1;
          gnt_id      = PTR_W'(sel);
        end
      end
    end
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
  end

  assign rd_addr = clr_acc ? iv_clr_cq_index : iv_req_cq_index[gnt_id*CQ_IDX_W +: CQ_IDX_W];
  assign acc_lsz = iv_req_cq_log_size[gnt_id*LOG_SZ_W +: LOG_SZ_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
    rdata_p1_q <= mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    id_p1_q      <= gnt_id;
    idx_p1_q     <= rd_addr;
    lsz_p1_q     <= acc_lsz;
    wr_idx_p2_q  <= wr_addr;
    wr_data_p2_q <= wr_data;
  end

  // Stage 1: RAM data returns; the RAM reads old data on a same-cycle write,
  // so the previous cycle's write is forwarded from the delayed write register.
  always_comb begin
    cur_p1  = (wr_vld_p2_q && (wr_idx_p2_q == idx_p1_q)) ? wr_data_p2_q : rdata_p1_q;
    len_p1  = ring_len(lsz_p1_q);
    nxt_p1  = {1'b0, cur_p1[OFFSET_W-1:0]} + LEN_W'(CQE_LEN);
    wrap_p1 = (nxt_p1 >= len_p1);
    upd_p1  = wrap_p1 ? {~cur_p1[OFFSET_W], OFFSET_W'(0)}
                      : {cur_p1[OFFSET_W], nxt_p1[OFFSET_W-1:0]};
    we      = (state_q == ST_INIT) | vld_p1_q;
    wr_addr = (state_q == ST_INIT) ? cnt_q : idx_p1_q;
    wr_data = ((state_q == ST_INIT) || clr_p1_q) ? '0 : upd_p1;
  end

  always_comb begin
    resp_vld_d = '0;
    resp_off_d = '0;
    resp_own_d = '0;
    if (vld_p1_q && !clr_p1_q) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (PTR_W'(r) == id_p1_q) begin
          resp_vld_d[r]                      = 1'b1;
          resp_off_d[r*OFFSET_W +: OFFSET_W] = cur_p1[OFFSET_W-1:0];
          resp_own_d[r]                      = cur_p1[OFFSET_W];
        end
      end
    end
  end

  // Stage 2: registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_fin_q  <= 1'b0;
      ptr_q       <= '0;
      vld_p1_q    <= 1'b0;
      clr_p1_q    <= 1'b0;
      wr_vld_p2_q <= 1'b0;
      resp_vld_q  <= '0;
      resp_off_q  <= '0;
      resp_own_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_fin_q  <= init_fin_d;
      ptr_q       <= ptr_d;
      vld_p1_q    <= gnt_any | clr_acc;
      clr_p1_q    <= clr_acc;
      wr_vld_p2_q <= we;
      resp_vld_q  <= resp_vld_d;
      resp_off_q  <= resp_off_d;
      resp_own_q  <= resp_own_d;
    end
  end

  assign o_req_ready       = gnt;
  assign o_clr_ready       = clr_acc;
  assign o_resp_valid      = resp_vld_q;
  assign ov_resp_cq_offset = resp_off_q;
  assign ov_resp_owner     = resp_own_q;
  assign o_init_finish     = init_fin_q;

`ifdef CQ_OFFSET_STAT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] gcnt_q [NUM_REQ];
  logic [31:0] wcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REQ; r++) gcnt_q[r] <= '0;
      wcnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) if (gnt[r]) gcnt_q[r] <= sat_inc(gcnt_q[r]);
      if (vld_p1_q && !clr_p1_q && wrap_p1) wcnt_q <= sat_inc(wcnt_q);
    end
  end

  always_comb begin
    ov_stat = '0;
    for (int r = 0; r < NUM_REQ; r++) ov_stat[r*32 +: 32] = gcnt_q[r];
    ov_stat[NUM_REQ*32 +: 32] = wcnt_q;
  end
`endif

endmodule

// File: tb/tb_cq_offset_rr_mgt.sv
// Bench for cq_offset_rr_mgt: directed steps plus random traffic against a table-level reference model.
module tb_cq_offset_rr_mgt;
  localparam int NUM_REQ  = 3;
  localparam int CQ_NUM   = 16384;
  localparam int CQ_IDX_W = 14;
  localparam int OFFSET_W = 24;
  localparam int CQE_LEN  = 32;
  localparam int LOG_SZ_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*CQ_IDX_W-1:0] req_idx = '0;
  logic [NUM_REQ*LOG_SZ_W-1:0] req_lsz = '0;
  logic [NUM_REQ-1:0]          resp_valid;
  logic [NUM_REQ*OFFSET_W-1:0] resp_off;
  logic [NUM_REQ-1:0]          resp_own;
  logic                        clr_valid = 1'b0;
  logic [CQ_IDX_W-1:0]         clr_idx = '0;
  logic                        clr_ready;
  logic                        init_finish;
`ifdef CQ_OFFSET_STAT_EN
  logic [NUM_REQ*32+31:0]      stat;
`endif

  cq_offset_rr_mgt #(
    .NUM_REQ(NUM_REQ), .CQ_NUM(CQ_NUM), .CQ_IDX_W(CQ_IDX_W),
    .OFFSET_W(OFFSET_W), .CQE_LEN(CQE_LEN), .LOG_SZ_W(LOG_SZ_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .iv_req_cq_index(req_idx), .iv_req_cq_log_size(req_lsz),
    .o_resp_valid(resp_valid), .ov_resp_cq_offset(resp_off), .ov_resp_owner(resp_own),
    .i_clr_valid(clr_valid), .iv_clr_cq_index(clr_idx), .o_clr_ready(clr_ready),
    .o_init_finish(init_finish)
`ifdef CQ_OFFSET_STAT_EN
    , .ov_stat(stat)
`endif
  );

  typedef struct { int due; int id; int off; bit own; } rsp_t;

  int   m_off [CQ_NUM];
  bit   m_own [CQ_NUM];
  int   m_ptr;
  int   gnt_cnt [NUM_REQ];
  int   wrap_cnt;
  bit   in_run;
  rsp_t pend [$];

  logic [NUM_REQ-1:0] nv_valid;
  int   nv_idx [NUM_REQ];
  int   nv_lsz [NUM_REQ];
  bit   nv_clr;
  int   nv_clr_idx;
  bit   nv_rst;
  int   last_gnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < CQ_NUM; i++) begin m_off[i] = 0; m_own[i] = 1'b0; end
    for (int r = 0; r < NUM_REQ; r++) gnt_cnt[r] = 0;
    m_ptr = 0; wrap_cnt = 0; in_run = 1'b0; pend.delete();
  endtask

  task automatic alloc(input int id, input int idx, input int lsz);
    rsp_t e;
    int   len;
    len   = CQE_LEN * (1 << lsz);
    e.due = cyc + 2; e.id = id; e.off = m_off[idx]; e.own = m_own[idx];
    pend.push_back(e);
    gnt_cnt[id]++;
    if (m_off[idx] + CQE_LEN >= len) begin
      m_off[idx] = 0; m_own[idx] = ~m_own[idx]; wrap_cnt++;
    end else begin
      m_off[idx] = m_off[idx] + CQE_LEN;
    end
  endtask

  task automatic idle();
    nv_valid = '0; nv_clr = 1'b0; nv_clr_idx = 0;
    for (int r = 0; r < NUM_REQ; r++) begin nv_idx[r] = 0; nv_lsz[r] = 0; end
  endtask

  task automatic set_one(input int id, input int idx, input int lsz);
    idle();
    nv_valid[id] = 1'b1; nv_idx[id] = idx; nv_lsz[id] = lsz;
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] exp_v, exp_rdy;
    rsp_t rr;
    int g;
    @(negedge clk);
    cyc++;
    exp_v = '0;
    for (int i = 0; i < pend.size(); i++) if (pend[i].due == cyc) exp_v[pend[i].id] = 1'b1;
    check("resp_valid", resp_valid, exp_v);
    while (pend.size() > 0 && pend[0].due == cyc) begin
      rr = pend.pop_front();
      check("resp_offset", resp_off[rr.id*OFFSET_W +: OFFSET_W], rr.off);
      check("resp_owner", resp_own[rr.id], rr.own);
    end
    rst_n     = nv_rst;
    req_valid = nv_valid;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_idx[r*CQ_IDX_W +: CQ_IDX_W] = CQ_IDX_W'(nv_idx[r]);
      req_lsz[r*LOG_SZ_W +: LOG_SZ_W] = LOG_SZ_W'(nv_lsz[r]);
    end
    clr_valid = nv_clr;
    clr_idx   = CQ_IDX_W'(nv_clr_idx);
    #1;
    last_gnt = -1;
    if (nv_rst && in_run) begin
      exp_rdy = '0;
      g = -1;
      if (!nv_clr)
        for (int k = 0; k < NUM_REQ; k++)
          if (g < 0 && nv_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("clr_ready", clr_ready, nv_clr);
      if (nv_clr) begin
        m_off[nv_clr_idx] = 0; m_own[nv_clr_idx] = 1'b0;
      end else if (g >= 0) begin
        alloc(g, nv_idx[g], nv_lsz[g]);
        m_ptr = (g + 1) % NUM_REQ;
        last_gnt = g;
      end
    end
  endtask

  task automatic do_init();
    idle();
    nv_rst = 1'b1;
    step();
    for (int i = 1; i < CQ_NUM; i++) begin
      if (i == 10) begin nv_valid = '1; nv_clr = 1'b1; end
      else idle();
      step();
      if (i == 10) begin
        check("init_req_ready", req_ready, 3'b000);
        check("init_clr_ready", clr_ready, 1'b0);
      end
    end
    check("init_finish_early", init_finish, 1'b0);
    step();
    check("init_finish", init_finish, 1'b1);
    in_run = 1'b1;
  endtask

  initial begin
    reset_model();
    idle();
    nv_rst = 1'b0;
    nv_valid = '1; nv_clr = 1'b1;
    repeat (3) step();
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_clr_ready", clr_ready, 1'b0);
    check("rst_init_finish", init_finish, 1'b0);
    check("rst_resp_offset", resp_off, 0);
    check("rst_resp_owner", resp_own, 3'b000);

    do_init();

    // CQ 5, 4 entries: 0,32,64,96 then wrap to 0 with owner 1
    set_one(0, 5, 2);
    repeat (5) step();
    // untouched CQ reads back as cleared; requester 2 returns the pointer to 0
    set_one(2, CQ_NUM - 1, 3);
    step();
    // all requesters on CQ 7 continuously: strict rotation, consecutive offsets
    idle();
    nv_valid = '1;
    for (int r = 0; r < NUM_REQ; r++) begin nv_idx[r] = 7; nv_lsz[r] = 3; end
    for (int i = 0; i < 6; i++) begin
      step();
      check("rotation", last_gnt, i % NUM_REQ);
    end
    // clear CQ 7 wins over requester 1, which then sees the cleared entry
    set_one(1, 7, 3);
    nv_clr = 1'b1; nv_clr_idx = 7;
    step();
    nv_clr = 1'b0;
    step();
    // log_size 0: always offset 0, owner toggles
    set_one(0, 9, 0);
    repeat (4) step();
    idle();
    repeat (3) step();

    last_gnt = -1;
    idle();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (!nv_valid[r] || last_gnt == r) begin
          nv_valid[r] = ($urandom_range(0, 3) != 0);
          nv_idx[r]   = $urandom_range(0, 3);
          nv_lsz[r]   = nv_idx[r] % 3;
        end
      nv_clr     = ($urandom_range(0, 7) == 0);
      nv_clr_idx = $urandom_range(0, 3);
      step();
    end
    idle();
    repeat (3) step();

    // reset lands with one request in stage 1 and another being accepted
    set_one(0, 5, 2);
    step();
    set_one(1, 6, 2);
    reset_model();
    nv_rst = 1'b0;
    step();
    nv_valid = '1; nv_clr = 1'b1;
    repeat (3) step();
    check("midrst_req_ready", req_ready, 3'b000);
    check("midrst_clr_ready", clr_ready, 1'b0);
    check("midrst_init_finish", init_finish, 1'b0);
    do_init();

    set_one(0, 5, 2);
    step();
    set_one(2, 11, 3);
    repeat (10) step();
    idle();
    repeat (3) step();
`ifdef CQ_OFFSET_STAT_EN
    check("stat_req2", stat[2*32 +: 32], 10);
    check("stat_wrap", stat[NUM_REQ*32 +: 32], 1);
    check("stat_req0", stat[0 +: 32], gnt_cnt[0]);
    check("stat_req1", stat[32 +: 32], gnt_cnt[1]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
